// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared constants and types for the MIPS control / ALU slice.
//   - opcode constants  (instruction bits [31:26])
//   - funct constants   (instruction bits [5:0], R-type only)
//   - aluop constants   (main decoder -> ALU control class)
//   - aluctl constants  (ALU control -> ALU operation select)
//   - ctrl_t            (bundle of main-decoder strobes)
// ----------------------------------------------------------------------------
package mips_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;

    // ALU class produced by the main decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operation select
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    // Main-decoder output bundle
    typedef struct packed {
        logic       regdst;
        logic       branch_eq;
        logic       branch_ne;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrc;
        logic       jump;
        logic [1:0] aluop;
    } ctrl_t;

    // All-strobes-off control word, used for NOP / unknown opcodes
    localparam ctrl_t CTRL_NOP = '{
        regdst:    1'b0,
        branch_eq: 1'b0,
        branch_ne: 1'b0,
        memread:   1'b0,
        memwrite:  1'b0,
        memtoreg:  1'b0,
        regwrite:  1'b0,
        alusrc:    1'b0,
        jump:      1'b0,
        aluop:     ALUOP_ADD
    };

    // Zero detect on a 32-bit result
    function automatic logic is_zero32(input logic [31:0] value);
        return (value == 32'h0000_0000);
    endfunction

endpackage

// File: rtl/mips_alu_core.sv
// ----------------------------------------------------------------------------
// mips_alu_core
// Purely combinational 32-bit ALU with zero detect.
// Ports:
//   aluctl [3:0]  in  : operation select (ALU_* constants)
//   a      [31:0] in  : operand A
//   b      [31:0] in  : operand B
//   result [31:0] out : operation result, unselected codes give 0
//   zero          out : result == 0 (valid for every operation, slt included)
// ----------------------------------------------------------------------------
module mips_alu_core
    import mips_pkg::*;
(
    input  logic [3:0]  aluctl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero
);

    logic [31:0] result_s;

    // Operation select; add/sub wrap modulo 2^32 with no overflow trap
    always_comb begin
        result_s = 32'h0000_0000;
        case (aluctl)
            ALU_AND: result_s = a & b;
            ALU_OR:  result_s = a | b;
            ALU_ADD: result_s = a + b;
            ALU_SUB: result_s = a - b;
            ALU_SLT: begin
                if ($signed(a) < $signed(b)) begin
                    result_s = 32'h0000_0001;
                end else begin
                    result_s = 32'h0000_0000;
                end
            end
            ALU_NOR: result_s = ~(a | b);
            ALU_XOR: result_s = a ^ b;
            default: result_s = 32'h0000_0000;
        endcase
    end

    assign result = result_s;
    assign zero   = is_zero32(result_s);

endmodule

// File: rtl/mips_ctrl_alu.sv
// ----------------------------------------------------------------------------
// mips_ctrl_alu
// Main decoder + ALU control + 32-bit ALU for the five-stage MIPS core, with
// an EX/MEM-style output register (priority rst > flush > hold > load).
// Ports:
//   clk, rst            in  : rising-edge clock, async active-high reset
//   opcode [5:0]        in  : instruction bits [31:26]
//   funct  [5:0]        in  : instruction bits [5:0]
//   a, b   [31:0]       in  : ALU operands
//   hold, flush         in  : output register control
//   regdst .. jump      out : decoded control strobes (combinational)
//   aluop  [1:0]        out : decoded ALU class (combinational)
//   aluctl [3:0]        out : ALU operation (combinational)
//   alu_out [31:0], zero out: ALU result and zero flag (combinational)
//   alu_out_q, zero_q   out : registered result and zero flag
// ----------------------------------------------------------------------------
module mips_ctrl_alu
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hold,
    input  logic        flush,
    output logic        regdst,
    output logic        branch_eq,
    output logic        branch_ne,
    output logic        memread,
    output logic        memwrite,
    output logic        memtoreg,
    output logic        regwrite,
    output logic        alusrc,
    output logic        jump,
    output logic [1:0]  aluop,
    output logic [3:0]  aluctl,
    output logic [31:0] alu_out,
    output logic        zero,
    output logic [31:0] alu_out_q,
    output logic        zero_q
);

    ctrl_t       ctrl_s;
    logic [3:0]  aluctl_s;
    logic [31:0] alu_result_s;
    logic        alu_zero_s;
    logic [31:0] alu_out_r;
    logic        zero_r;

    // Main decoder: opcode to datapath strobes, unknown opcodes act as NOP
    always_comb begin
        ctrl_s = CTRL_NOP;
        case (opcode)
            OP_RTYPE: begin
                ctrl_s.regdst   = 1'b1;
                ctrl_s.regwrite = 1'b1;
                ctrl_s.aluop    = ALUOP_FUNCT;
            end
            OP_LW: begin
                ctrl_s.memread  = 1'b1;
                ctrl_s.memtoreg = 1'b1;
                ctrl_s.regwrite = 1'b1;
                ctrl_s.alusrc   = 1'b1;
                ctrl_s.aluop    = ALUOP_ADD;
            end
            OP_SW: begin
                ctrl_s.memwrite = 1'b1;
                ctrl_s.alusrc   = 1'b1;
                ctrl_s.aluop    = ALUOP_ADD;
            end
            OP_ADDI: begin
                ctrl_s.regwrite = 1'b1;
                ctrl_s.alusrc   = 1'b1;
                ctrl_s.aluop    = ALUOP_ADD;
            end
            OP_BEQ: begin
                ctrl_s.branch_eq = 1'b1;
                ctrl_s.aluop     = ALUOP_SUB;
            end
            OP_BNE: begin
                ctrl_s.branch_ne = 1'b1;
                ctrl_s.aluop     = ALUOP_SUB;
            end
            OP_J: begin
                ctrl_s.jump  = 1'b1;
                ctrl_s.aluop = ALUOP_ADD;
            end
            default: ctrl_s = CTRL_NOP;
        endcase
    end

    // ALU control: class from the decoder, R-type refined by funct.
    // aluop 11 is never produced by the decoder but still maps to add.
    always_comb begin
        aluctl_s = ALU_ADD;
        case (ctrl_s.aluop)
            ALUOP_ADD: aluctl_s = ALU_ADD;
            ALUOP_SUB: aluctl_s = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   aluctl_s = ALU_ADD;
                    F_SUB:   aluctl_s = ALU_SUB;
                    F_AND:   aluctl_s = ALU_AND;
                    F_OR:    aluctl_s = ALU_OR;
                    F_XOR:   aluctl_s = ALU_XOR;
                    F_NOR:   aluctl_s = ALU_NOR;
                    F_SLT:   aluctl_s = ALU_SLT;
                    default: aluctl_s = ALU_ADD;
                endcase
            end
            default: aluctl_s = ALU_ADD;
        endcase
    end

    mips_alu_core u_alu_core (
        .aluctl (aluctl_s),
        .a      (a),
        .b      (b),
        .result (alu_result_s),
        .zero   (alu_zero_s)
    );

    // Output register: flush wins over hold, hold keeps the current value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_out_r <= 32'h0000_0000;
            zero_r    <= 1'b0;
        end else if (flush) begin
            alu_out_r <= 32'h0000_0000;
            zero_r    <= 1'b0;
        end else if (hold) begin
            alu_out_r <= alu_out_r;
            zero_r    <= zero_r;
        end else begin
            alu_out_r <= alu_result_s;
            zero_r    <= alu_zero_s;
        end
    end

    assign regdst    = ctrl_s.regdst;
    assign branch_eq = ctrl_s.branch_eq;
    assign branch_ne = ctrl_s.branch_ne;
    assign memread   = ctrl_s.memread;
    assign memwrite  = ctrl_s.memwrite;
    assign memtoreg  = ctrl_s.memtoreg;
    assign regwrite  = ctrl_s.regwrite;
    assign alusrc    = ctrl_s.alusrc;
    assign jump      = ctrl_s.jump;
    assign aluop     = ctrl_s.aluop;
    assign aluctl    = aluctl_s;
    assign alu_out   = alu_result_s;
    assign zero      = alu_zero_s;
    assign alu_out_q = alu_out_r;
    assign zero_q    = zero_r;

endmodule

// File: tb/tb_mips_ctrl_alu.sv
// ----------------------------------------------------------------------------
// tb_mips_ctrl_alu
// Directed self-checking bench for mips_ctrl_alu. Expected values are
// hand-computed constants. Strobes are compared as one 9-bit vector in the
// order {regdst, branch_eq, branch_ne, memread, memwrite, memtoreg,
// regwrite, alusrc, jump}.
// ----------------------------------------------------------------------------
module tb_mips_ctrl_alu;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic        hold;
    logic        flush;
    logic        regdst, branch_eq, branch_ne, memread, memwrite;
    logic        memtoreg, regwrite, alusrc, jump;
    logic [1:0]  aluop;
    logic [3:0]  aluctl;
    logic [31:0] alu_out;
    logic        zero;
    logic [31:0] alu_out_q;
    logic        zero_q;

    int checks;
    int errors;

    mips_ctrl_alu dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .funct     (funct),
        .a         (a),
        .b         (b),
        .hold      (hold),
        .flush     (flush),
        .regdst    (regdst),
        .branch_eq (branch_eq),
        .branch_ne (branch_ne),
        .memread   (memread),
        .memwrite  (memwrite),
        .memtoreg  (memtoreg),
        .regwrite  (regwrite),
        .alusrc    (alusrc),
        .jump      (jump),
        .aluop     (aluop),
        .aluctl    (aluctl),
        .alu_out   (alu_out),
        .zero      (zero),
        .alu_out_q (alu_out_q),
        .zero_q    (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] strobes();
        return {regdst, branch_eq, branch_ne, memread, memwrite,
                memtoreg, regwrite, alusrc, jump};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a new instruction/operand set and let combinational logic settle
    task automatic apply(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] av, input logic [31:0] bv);
        opcode = op;
        funct  = fn;
        a      = av;
        b      = bv;
        #1;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        hold   = 1'b0;
        flush  = 1'b0;
        opcode = 6'b000000;
        funct  = 6'b100000;
        a      = 32'h0000_0003;
        b      = 32'h0000_0004;

        // Reset state held across an edge
        tick();
        chk("rst_q",    alu_out_q, 32'h0);
        chk("rst_zq",   {31'b0, zero_q}, 32'h0);
        rst = 1'b0;

        // lw: address add, then registered after one edge
        apply(6'b100011, 6'b000000, 32'h10, 32'h4);
        chk("lw_strb",  {23'b0, strobes()}, {23'b0, 9'b000101110});
        chk("lw_aluop", {30'b0, aluop}, 32'h0);
        chk("lw_ctl",   {28'b0, aluctl}, 32'h2);
        chk("lw_out",   alu_out, 32'h14);
        chk("lw_zero",  {31'b0, zero}, 32'h0);
        tick();
        chk("lw_q",     alu_out_q, 32'h14);
        chk("lw_zq",    {31'b0, zero_q}, 32'h0);

        // sw and addi strobes, addi wraps
        apply(6'b101011, 6'b000000, 32'h100, 32'h8);
        chk("sw_strb",  {23'b0, strobes()}, {23'b0, 9'b000010010});
        chk("sw_out",   alu_out, 32'h108);
        apply(6'b001000, 6'b000000, 32'h100, 32'hFFFF_FFFF);
        chk("addi_strb", {23'b0, strobes()}, {23'b0, 9'b000000110});
        chk("addi_out", alu_out, 32'hFF);

        // slt signed both ways
        apply(6'b000000, 6'b101010, 32'hFFFF_FFFF, 32'h1);
        chk("r_strb",   {23'b0, strobes()}, {23'b0, 9'b100000100});
        chk("r_aluop",  {30'b0, aluop}, 32'h2);
        chk("slt_ctl",  {28'b0, aluctl}, 32'h7);
        chk("slt1_out", alu_out, 32'h1);
        chk("slt1_z",   {31'b0, zero}, 32'h0);
        apply(6'b000000, 6'b101010, 32'h1, 32'hFFFF_FFFF);
        chk("slt0_out", alu_out, 32'h0);
        chk("slt0_z",   {31'b0, zero}, 32'h1);

        // beq / bne
        apply(6'b000100, 6'b000000, 32'h1234, 32'h1234);
        chk("beq_strb", {23'b0, strobes()}, {23'b0, 9'b010000000});
        chk("beq_aluop", {30'b0, aluop}, 32'h1);
        chk("beq_ctl",  {28'b0, aluctl}, 32'h6);
        chk("beq_z",    {31'b0, zero}, 32'h1);
        apply(6'b000101, 6'b000000, 32'h5, 32'h3);
        chk("bne_strb", {23'b0, strobes()}, {23'b0, 9'b001000000});
        chk("bne_out",  alu_out, 32'h2);
        chk("bne_z",    {31'b0, zero}, 32'h0);

        // R-type logic / arithmetic ops
        apply(6'b000000, 6'b100111, 32'h0, 32'h0);
        chk("nor_ctl",  {28'b0, aluctl}, 32'hC);
        chk("nor_out",  alu_out, 32'hFFFF_FFFF);
        apply(6'b000000, 6'b100000, 32'h7FFF_FFFF, 32'h1);
        chk("add_wrap", alu_out, 32'h8000_0000);
        apply(6'b000000, 6'b111111, 32'h3, 32'h4);
        chk("unk_ctl",  {28'b0, aluctl}, 32'h2);
        chk("unk_out",  alu_out, 32'h7);
        apply(6'b000000, 6'b100100, 32'h0000_F0F0, 32'h0000_FF00);
        chk("and_out",  alu_out, 32'h0000_F000);
        apply(6'b000000, 6'b100101, 32'h0000_F0F0, 32'h0000_FF00);
        chk("or_out",   alu_out, 32'h0000_FFF0);
        apply(6'b000000, 6'b100110, 32'h0000_F0F0, 32'h0000_FF00);
        chk("xor_ctl",  {28'b0, aluctl}, 32'hD);
        chk("xor_out",  alu_out, 32'h0000_0FF0);
        apply(6'b000000, 6'b100010, 32'h5, 32'h7);
        chk("sub_out",  alu_out, 32'hFFFF_FFFE);

        // Unknown opcode is a NOP; j raises jump only
        apply(6'b111111, 6'b100010, 32'h5, 32'h7);
        chk("nop_strb", {23'b0, strobes()}, 32'h0);
        chk("nop_aluop", {30'b0, aluop}, 32'h0);
        chk("nop_ctl",  {28'b0, aluctl}, 32'h2);
        apply(6'b000010, 6'b000000, 32'h5, 32'h7);
        chk("j_strb",   {23'b0, strobes()}, {23'b0, 9'b000000001});
        chk("j_aluop",  {30'b0, aluop}, 32'h0);

        // Register: load, hold, flush-over-hold
        apply(6'b000000, 6'b100000, 32'h55, 32'h0);
        tick();
        chk("ld_q",     alu_out_q, 32'h55);
        hold = 1'b1;
        apply(6'b000000, 6'b100000, 32'h99, 32'h0);
        chk("hold_out", alu_out, 32'h99);
        tick();
        chk("hold_q",   alu_out_q, 32'h55);
        flush = 1'b1;
        tick();
        chk("flush_q",  alu_out_q, 32'h0);
        chk("flush_zq", {31'b0, zero_q}, 32'h0);
        flush = 1'b0;
        hold  = 1'b0;

        // zero flag is captured too
        apply(6'b000100, 6'b000000, 32'h1234, 32'h1234);
        tick();
        chk("zq_set",   {31'b0, zero_q}, 32'h1);
        chk("zq_out",   alu_out_q, 32'h0);

        // Asynchronous reset between edges, then reload on first edge after
        apply(6'b000000, 6'b100000, 32'h55, 32'h0);
        tick();
        chk("pre_rst_q", alu_out_q, 32'h55);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_q",   alu_out_q, 32'h0);
        chk("arst_zq",  {31'b0, zero_q}, 32'h0);
        rst = 1'b0;
        tick();
        chk("post_rst_q", alu_out_q, 32'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_ctrl_alu.md
# mips_ctrl_alu

Combined main-decoder, ALU-control and 32-bit ALU for the five-stage MIPS core. Decodes `opcode` into datapath control strobes and derives a 4-bit ALU operation from `aluop` and `funct`. Executes that operation on `a`/`b` combinationally, and captures result and zero flag in an EX/MEM-style output register with hold and flush.

## Interface
- Clocking: one clock; reset is asynchronous and active-high.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset of the output register.
- `opcode` in 6: instruction bits [31:26].
- `funct` in 6: instruction bits [5:0].
- `a` in 32: ALU operand A.
- `b` in 32: ALU operand B.
- `hold` in 1: output register keeps its value.
- `flush` in 1: output register loads zeros.
- `regdst`, `branch_eq`, `branch_ne`, `memread`, `memwrite`, `memtoreg`, `regwrite`, `alusrc`, `jump` out 1 each: decoded control, combinational.
- `aluop` out 2: decoded ALU class, combinational.
- `aluctl` out 4: ALU operation, combinational.
- `alu_out` out 32: ALU result, combinational.
- `zero` out 1: `alu_out == 0`, combinational.
- `alu_out_q` out 32: registered result.
- `zero_q` out 1: registered zero flag.

## Operation
Main decoder (all strobes 0 unless listed):
- 000000 R-type: regdst, regwrite, aluop=10.
- 100011 lw: memread, memtoreg, regwrite, alusrc, aluop=00.
- 101011 sw: memwrite, alusrc, aluop=00.
- 001000 addi: regwrite, alusrc, aluop=00.
- 000100 beq: branch_eq, aluop=01.
- 000101 bne: branch_ne, aluop=01.
- 000010 j: jump, aluop=00.
- Any other opcode: all strobes 0, aluop=00 (NOP).

ALU control, using the decoder's `aluop` and the `funct` input:
- aluop 00 → 0010 (add).
- aluop 01 → 0110 (sub).
- aluop 11 → 0010 (add).
- aluop 10, by funct:
  - 100000 → 0010 (add)
  - 100010 → 0110 (sub)
  - 100100 → 0000 (and)
  - 100101 → 0001 (or)
  - 100110 → 1101 (xor)
  - 100111 → 1100 (nor)
  - 101010 → 0111 (slt)
  - any other funct → 0010 (add)

ALU, by `aluctl`:
- 0000 a&b
- 0001 a|b
- 0010 a+b, modulo 2^32, no overflow trap
- 0110 a−b, modulo 2^32
- 0111 1 if $signed(a) < $signed(b), else 0
- 1100 ~(a|b)
- 1101 a^b
- any other code → 0

`zero` is derived from `alu_out` for every operation, slt included.

## Timing
- Decoder, ALU control and ALU: purely combinational, zero latency from inputs.
- Output register on posedge `clk`, priority `rst` > `flush` > `hold` > load:
  - `rst` high: `alu_out_q`=0 and `zero_q`=0 immediately, independent of `clk`.
  - `flush`: loads 0 into both, even when `hold` is also high.
  - `hold`: retains current value.
  - Otherwise: loads `alu_out` and `zero`.
- Register latency: one cycle.
- Reset released mid-stream: first load happens on the first rising edge after deassertion.
- Reset values: `alu_out_q`=0, `zero_q`=0. Combinational outputs have no reset; they always reflect their inputs.

## Structure
- Shared package `mips_pkg`:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_BNE, OP_J
  - funct constants: F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT
  - aluop constants: ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
  - aluctl constants: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_XOR
- One natural sub-module, `mips_alu_core`: the ALU plus zero detect. Decoders and the output register stay in the top.

## Test plan
- opcode 100011 → memread=memtoreg=regwrite=alusrc=1, aluop=00, aluctl=0010; a=0x10, b=0x4 → alu_out=0x14; after one edge alu_out_q=0x14.
- opcode 000000, funct 101010, a=0xFFFFFFFF, b=1 → aluctl=0111, alu_out=1, zero=0. Same with a=1, b=0xFFFFFFFF → alu_out=0, zero=1.
- opcode 000100, a=b=0x1234 → branch_eq=1, aluctl=0110, zero=1. opcode 000101 with a=5, b=3 → branch_ne=1, alu_out=2, zero=0.
- R-type funct 100111, a=0, b=0 → alu_out=0xFFFFFFFF. Funct 100000, a=0x7FFFFFFF, b=1 → 0x80000000 (wraps, no trap). Unknown funct 111111 → add.
- opcode 111111 → all strobes 0, aluop=00. opcode 000010 → jump=1 only.
- Register control:
  - load 0x55, then hold=1 with alu_out=0x99 → alu_out_q stays 0x55
  - flush=1 together with hold=1 → 0
  - rst asserted between edges → 0 immediately
